// File: rtl/spi_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_ram_pkg
// Description : Command encodings and FSM state type for the SPI/RAM bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_ram_pkg;

  // Two-bit command field, sent MSB first at the start of every frame
  localparam logic [1:0] CMD_SET_WADDR = 2'b00;
  localparam logic [1:0] CMD_WRITE     = 2'b01;
  localparam logic [1:0] CMD_SET_RADDR = 2'b10;
  localparam logic [1:0] CMD_READ      = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CMD      = 3'd1,
    PAYLOAD  = 3'd2,
    DONE     = 3'd3,
    RD_LOAD  = 3'd4,
    RD_SHIFT = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_ram_mem.sv
`default_nettype none
// ============================================================================
// Module      : spi_ram_mem
// Description : 2**ADDR_W x DATA_W RAM, synchronous write, asynchronous read.
//               Contents are deliberately not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_ram_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  // Single write port, committed on the clock edge when enabled
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/spi_ram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : spi_ram_bridge
// Description : SPI slave (bit clock = clk) that sets RAM write/read pointers
//               or streams bursts of words into / out of an internal RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_ram_bridge
  import spi_ram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int AUTO_INC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic MOSI,
  input  logic SS_n,
  output logic MISO,
  output logic busy
);

  localparam int              CNT_W  = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DATA_W - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_cmd;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-2:0]   r_rx;
  logic [DATA_W-1:0]   r_tx;
  logic [ADDR_W-1:0]   r_wptr;
  logic [ADDR_W-1:0]   r_rptr;
  logic [DATA_W-1:0]   w_word;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_last;
  logic                w_mem_we;

  // Word as it stands once the bit on MOSI this edge is included
  assign w_word = {r_rx, MOSI};
  assign w_last = (r_cnt == c_LAST);
  assign busy   = (r_state != IDLE);

  spi_ram_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (r_wptr),
    .i_wdata (w_word),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and RAM write strobe; SS_n high always wins
  always_comb begin
    w_state_nxt = r_state;
    w_mem_we    = 1'b0;
    if (SS_n) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:     w_state_nxt = CMD;
        CMD:      w_state_nxt = ({r_cmd[1], MOSI} == CMD_READ) ? RD_LOAD : PAYLOAD;
        PAYLOAD: begin
          if (w_last) begin
            if (r_cmd == CMD_WRITE) begin
              w_mem_we = 1'b1;
            end else begin
              w_state_nxt = DONE;
            end
          end
        end
        DONE:     w_state_nxt = DONE;
        RD_LOAD:  w_state_nxt = RD_SHIFT;
        RD_SHIFT: w_state_nxt = RD_SHIFT;
        default:  w_state_nxt = IDLE;
      endcase
    end
  end

  // Datapath: command capture, shift registers, bit counter, pointers, MISO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd  <= '0;
      r_cnt  <= '0;
      r_rx   <= '0;
      r_tx   <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      MISO   <= 1'b0;
    end else begin
      MISO <= (!SS_n && (r_state == RD_LOAD || r_state == RD_SHIFT)) ? r_tx[DATA_W-1] : 1'b0;
      if (SS_n) begin
        r_cnt <= '0;
        r_tx  <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_cmd[1] <= MOSI;
            r_cnt    <= '0;
            r_tx     <= '0;
          end
          CMD: begin
            r_cmd[0] <= MOSI;
            r_cnt    <= '0;
            r_rx     <= '0;
          end
          PAYLOAD: begin
            r_rx <= w_word[DATA_W-2:0];
            if (w_last) begin
              r_cnt <= '0;
              case (r_cmd)
                CMD_SET_WADDR: r_wptr <= w_word[ADDR_W-1:0];
                CMD_SET_RADDR: r_rptr <= w_word[ADDR_W-1:0];
                CMD_WRITE:     if (AUTO_INC != 0) r_wptr <= r_wptr + ADDR_W'(1);
                default:       ;
              endcase
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          RD_LOAD: begin
            r_tx  <= w_rdata;
            r_cnt <= '0;
            if (AUTO_INC != 0) r_rptr <= r_rptr + ADDR_W'(1);
          end
          RD_SHIFT: begin
            if (w_last) begin
              // Prefetch the next word so the stream has no gap cycle
              r_tx  <= w_rdata;
              r_cnt <= '0;
              if (AUTO_INC != 0) r_rptr <= r_rptr + ADDR_W'(1);
            end else begin
              r_tx  <= {r_tx[DATA_W-2:0], 1'b0};
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_ram_bridge
// Description : Table-driven frame bench for spi_ram_bridge (three parameter
//               sets) with a read-word scoreboard and hand-written reset case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_ram_bridge;
  import spi_ram_pkg::*;

  typedef struct {
    int               dut;
    logic [1:0]       cmd;
    int               nw;
    logic [3:0][15:0] w;
    int               extra;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic r_mosi [3];
  logic r_ssn  [3];
  logic w_miso [3];
  logic w_busy [3];

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] sb_q [$];
  vec_t        tbl  [$];

  always #5 clk = ~clk;

  spi_ram_bridge #(.DATA_W(8), .ADDR_W(8), .AUTO_INC(1)) u0 (
    .clk(clk), .rst(rst), .MOSI(r_mosi[0]), .SS_n(r_ssn[0]),
    .MISO(w_miso[0]), .busy(w_busy[0]));
  spi_ram_bridge #(.DATA_W(8), .ADDR_W(8), .AUTO_INC(0)) u1 (
    .clk(clk), .rst(rst), .MOSI(r_mosi[1]), .SS_n(r_ssn[1]),
    .MISO(w_miso[1]), .busy(w_busy[1]));
  spi_ram_bridge #(.DATA_W(16), .ADDR_W(4), .AUTO_INC(1)) u2 (
    .clk(clk), .rst(rst), .MOSI(r_mosi[2]), .SS_n(r_ssn[2]),
    .MISO(w_miso[2]), .busy(w_busy[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int d, input logic [1:0] c, input int n,
                              input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] e, input int x);
    vec_t v;
    v.dut   = d;
    v.cmd   = c;
    v.nw    = n;
    v.w[0]  = a;
    v.w[1]  = b;
    v.w[2]  = e;
    v.w[3]  = '0;
    v.extra = x;
    return v;
  endfunction

  // One complete frame; READ words are queued first, then popped as received
  task automatic frame(input vec_t v);
    int          d  = v.dut;
    int          dw = (v.dut == 2) ? 16 : 8;
    logic [15:0] got;
    logic [15:0] exp;
    r_ssn[d]  = 1'b0;
    r_mosi[d] = v.cmd[1];
    tick();
    r_mosi[d] = v.cmd[0];
    tick();
    if (v.cmd == CMD_READ) begin
      for (int i = 0; i < v.nw; i++) sb_q.push_back(v.w[i]);
      r_mosi[d] = 1'($urandom);
      tick();
      for (int i = 0; i < v.nw; i++) begin
        got = '0;
        for (int b = 0; b < dw; b++) begin
          r_mosi[d] = 1'($urandom);
          tick();
          got = {got[14:0], w_miso[d]};
        end
        exp = sb_q.pop_front();
        check($sformatf("read_d%0d_w%0d", d, i), 32'(got), 32'(exp));
      end
    end else begin
      for (int i = 0; i < v.nw; i++) begin
        for (int b = dw - 1; b >= 0; b--) begin
          r_mosi[d] = v.w[i][b];
          tick();
        end
      end
      for (int b = 0; b < v.extra; b++) begin
        r_mosi[d] = 1'b1;
        tick();
      end
    end
    r_ssn[d]  = 1'b1;
    r_mosi[d] = 1'b0;
    tick();
    check($sformatf("busy_end_d%0d", d), 32'(w_busy[d]), 32'd0);
    tick();
    check($sformatf("miso_idle_d%0d", d), 32'(w_miso[d]), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      r_mosi[i] = 1'b0;
      r_ssn[i]  = 1'b1;
    end
    rst = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_miso_d%0d", i), 32'(w_miso[i]), 32'd0);
      check($sformatf("rst_busy_d%0d", i), 32'(w_busy[i]), 32'd0);
    end
    check("rst_wptr", 32'(u0.r_wptr), 32'd0);
    check("rst_rptr", 32'(u0.r_rptr), 32'd0);
    rst = 1'b0;
    tick();

    // Burst write/read, wrap-around, early SS_n, AUTO_INC=0, 16-bit sweep
    tbl.push_back(mk(0, CMD_SET_WADDR, 1, 16'h10, 0, 0, 0));
    tbl.push_back(mk(0, CMD_WRITE,     3, 16'hA5, 16'h3C, 16'hFF, 0));
    tbl.push_back(mk(0, CMD_SET_RADDR, 1, 16'h10, 0, 0, 0));
    tbl.push_back(mk(0, CMD_READ,      3, 16'hA5, 16'h3C, 16'hFF, 0));
    tbl.push_back(mk(0, CMD_SET_WADDR, 1, 16'hFF, 0, 0, 0));
    tbl.push_back(mk(0, CMD_WRITE,     2, 16'h11, 16'h22, 0, 0));
    tbl.push_back(mk(0, CMD_SET_RADDR, 1, 16'hFF, 0, 0, 0));
    tbl.push_back(mk(0, CMD_READ,      2, 16'h11, 16'h22, 0, 0));
    tbl.push_back(mk(0, CMD_SET_RADDR, 1, 16'h00, 0, 0, 0));
    tbl.push_back(mk(0, CMD_READ,      1, 16'h22, 0, 0, 0));
    tbl.push_back(mk(0, CMD_SET_WADDR, 1, 16'h40, 0, 0, 0));
    tbl.push_back(mk(0, CMD_WRITE,     2, 16'h77, 16'h88, 0, 0));
    tbl.push_back(mk(0, CMD_WRITE,     0, 0, 0, 0, 5));
    tbl.push_back(mk(0, CMD_WRITE,     0, 0, 0, 0, 7));
    tbl.push_back(mk(0, CMD_WRITE,     1, 16'h99, 0, 0, 0));
    tbl.push_back(mk(0, CMD_SET_RADDR, 1, 16'h40, 0, 0, 0));
    tbl.push_back(mk(0, CMD_READ,      3, 16'h77, 16'h88, 16'h99, 0));
    tbl.push_back(mk(1, CMD_SET_WADDR, 1, 16'h05, 0, 0, 0));
    tbl.push_back(mk(1, CMD_WRITE,     2, 16'h01, 16'h02, 0, 0));
    tbl.push_back(mk(1, CMD_SET_RADDR, 1, 16'h05, 0, 0, 0));
    tbl.push_back(mk(1, CMD_READ,      2, 16'h02, 16'h02, 0, 0));
    tbl.push_back(mk(2, CMD_SET_WADDR, 1, 16'hFFF3, 0, 0, 0));
    tbl.push_back(mk(2, CMD_WRITE,     1, 16'hBEEF, 0, 0, 0));
    tbl.push_back(mk(2, CMD_SET_RADDR, 1, 16'h0003, 0, 0, 0));
    tbl.push_back(mk(2, CMD_READ,      1, 16'hBEEF, 0, 0, 0));
    for (int i = 0; i < tbl.size(); i++) frame(tbl[i]);

    // Pointer state after the table: partial words must not have advanced wr_ptr
    check("wptr_d0", 32'(u0.r_wptr), 32'h43);
    check("rptr_d0", 32'(u0.r_rptr), 32'h44);
    check("wptr_d1", 32'(u1.r_wptr), 32'h05);
    check("rptr_d1", 32'(u1.r_rptr), 32'h05);
    check("wptr_d2", 32'(u2.r_wptr), 32'h4);

    // Reset in the middle of a WRITE word, released with SS_n still low
    frame(mk(0, CMD_SET_WADDR, 1, 16'h20, 0, 0, 0));
    frame(mk(0, CMD_WRITE,     2, 16'hC3, 16'h3C, 0, 0));
    frame(mk(0, CMD_SET_WADDR, 1, 16'h21, 0, 0, 0));
    r_ssn[0]  = 1'b0;
    r_mosi[0] = 1'b0;
    tick();
    r_mosi[0] = 1'b1;
    tick();
    for (int b = 0; b < 7; b++) tick();
    check("busy_before_rst", 32'(w_busy[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_miso", 32'(w_miso[0]), 32'd0);
    check("midrst_busy", 32'(w_busy[0]), 32'd0);
    check("midrst_wptr", 32'(u0.r_wptr), 32'd0);
    check("midrst_rptr", 32'(u0.r_rptr), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    frame(mk(0, CMD_SET_RADDR, 1, 16'h20, 0, 0, 0));
    frame(mk(0, CMD_READ,      2, 16'hC3, 16'h3C, 0, 0));
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
